// File: rtl/key_pulse_conditioner.sv
// Two independent push-button conditioners: 2-FF synchronizer, debounce FSM and a
// registered one-cycle pulse per confirmed press. Keys are active-low, outputs active-high.
module key_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_start_n,
  input  logic key_stop_n,
  output logic start,
  output logic stop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    DOWN = 2'd2,
    REL  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] key_n;
  logic [1:0] pulse;

  assign key_n = {key_stop_n, key_start_n};
  assign start = pulse[0];
  assign stop  = pulse[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             s1_q;
    logic             s2_q;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;

    // Synchronizer flops reset to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_q <= 1'b1;
        s2_q <= 1'b1;
      end else begin
        s1_q <= key_n[ch];
        s2_q <= s1_q;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        IDLE: begin
          if (!s2_q) begin
            state_d = ARM;
            cnt_d   = '0;
          end
        end
        ARM: begin
          if (s2_q) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_MAX) begin
            state_d = DOWN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DOWN: begin
          if (s2_q) begin
            state_d = REL;
            cnt_d   = '0;
          end
        end
        REL: begin
          if (!s2_q) begin
            state_d = DOWN;
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Pulse fires only on the qualifying ARM->DOWN transition.
    always_comb begin
      pulse_d = (state_q == ARM) && !s2_q && (cnt_q == CNT_MAX);
    end

    assign pulse[ch] = pulse_q;
  end

endmodule
